hazard_control: RTL and testbench
=================================

HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 SHALL use one clock and one reset: reset is asynchronous and active-low. Ports CLK and nRST.
REQ-002 Port list (name  direction  width  meaning), one port per line:
- CLK  in  1  clock, all state on rising edge
- nRST  in  1  async active-low reset
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- dREN_MEM, dWEN_MEM  in  1 each  MEM-stage load / store pending
- memtoReg_EX  in  1  EX-stage instruction is a load
- RegWr_EX  in  1  EX-stage instruction writes a register
- wsel_EX  in  5  EX-stage destination register
- rs_ID, rt_ID  in  5 each  ID-stage source registers
- redirect_EX  in  1  taken branch/jump resolved in EX
- halt_WB  in  1  halt instruction in WB
- pc_en  out  1  PC update enable
- ifid_enable, ifid_flush  out  1 each  IF/ID latch controls
- idex_enable, idex_flush  out  1 each  ID/EX latch controls; drive enable/flush of decode_execute_if
- exmem_enable, memwb_enable  out  1 each  downstream latch enables
- halted  out  1  sticky halt indication
- stall_cnt  out  16  saturating stall-cycle count
- flush_cnt  out  16  saturating redirect count
REQ-003 Latch semantics SHALL be: flush=1 loads a bubble (all control fields 0) on the edge, regardless of enable; enable=0 with flush=0 holds; enable=1 loads.

Function
REQ-004 FSM states SHALL be RUN, DWAIT, HALTED; state register resets to RUN.
REQ-005 dstall SHALL be (dREN_MEM|dWEN_MEM) & ~dhit.
REQ-006 lu SHALL be memtoReg_EX & RegWr_EX & (wsel_EX!=0) & (wsel_EX==rs_ID | wsel_EX==rt_ID).
REQ-007 Transitions SHALL be as follows.
- RUN->HALTED: halt_WB & ~dstall.
- RUN->DWAIT: dstall.
- DWAIT->RUN: dhit.
- DWAIT->DWAIT: otherwise.
- HALTED: held until nRST.
REQ-008 HALTED or halt_WB (first priority) SHALL drive all enables 0 and all flushes 0, and halted=1 from the cycle after halt_WB is accepted.
REQ-009 dstall (second priority, in RUN or DWAIT) SHALL drive all enables 0, all flushes 0 and pc_en=0, freezing the whole pipe.
REQ-010 redirect_EX (third priority, no dstall) SHALL drive pc_en=1, ifid_flush=1, idex_flush=1 and all other enables 1. The ihit state SHALL be ignored. The wrong-path instruction is dropped.
REQ-011 lu (fourth priority) SHALL drive pc_en=0, ifid_enable=0 and idex_flush=1, with exmem/memwb enables 1. This inserts exactly one bubble, and lu self-clears the next cycle.
REQ-012 ~ihit (fifth priority) SHALL drive pc_en=0, ifid_enable=0 and idex_flush=1, with downstream enables 1. No instruction is duplicated.
REQ-013 Default (no condition) SHALL drive all enables 1, all flushes 0 and pc_en=1.
REQ-014 A dhit cycle in DWAIT SHALL evaluate REQ-010..013 normally in that same cycle, adding no extra latency.
REQ-015 Outputs pc_en, enables and flushes SHALL be combinational from state and inputs. halted, stall_cnt and flush_cnt SHALL be registered.
REQ-016 stall_cnt SHALL increment on each edge where pc_en=0 and state!=HALTED, and saturate at 0xFFFF.
REQ-017 flush_cnt SHALL increment on each edge where REQ-010 applies, and saturate at 0xFFFF.
REQ-018 Simultaneous halt_WB and dstall SHALL apply dstall first; halt is accepted on the dhit cycle.

Reset
REQ-019 nRST low SHALL immediately force the following, independent of CLK:
- state=RUN, halted=0, stall_cnt=0, flush_cnt=0.
- Outputs to REQ-013 values, or to REQ-012 values if ihit=0.
REQ-020 Reset mid-DWAIT or in HALTED SHALL return to RUN with counters cleared. There is no residual stall.

Verification
REQ-021 Load-use: memtoReg_EX=1, RegWr_EX=1, wsel_EX=5, rs_ID=5, ihit=1 -> exactly one cycle of pc_en=0, ifid_enable=0, idex_flush=1. stall_cnt goes 0->1.
REQ-022 Data wait: dREN_MEM=1, dhit=0 for 3 cycles, then dhit=1 -> all enables 0 for 3 cycles, state DWAIT, then all enables 1 on the dhit cycle. stall_cnt=3.
REQ-023 Redirect during ~ihit: redirect_EX=1, ihit=0 -> pc_en=1, ifid_flush=1, idex_flush=1. flush_cnt increments by 1.
REQ-024 Halt: halt_WB=1, no dstall -> halted=1 next cycle and all enables 0 thereafter. An ihit/redirect toggle has no effect. nRST pulse -> halted=0, state RUN.
REQ-025 wsel_EX=0 with rs_ID=0 and a load in EX -> no stall (lu=0).
REQ-026 Saturation: force 65,540 stall cycles -> stall_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/hazard_control.sv
// hazard_control: pipeline stall/flush arbitration with a RUN/DWAIT/HALTED
// FSM and saturating stall and redirect counters.
module hazard_control (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dREN_MEM,
  input  logic        dWEN_MEM,
  input  logic        memtoReg_EX,
  input  logic        RegWr_EX,
  input  logic [4:0]  wsel_EX,
  input  logic [4:0]  rs_ID,
  input  logic [4:0]  rt_ID,
  input  logic        redirect_EX,
  input  logic        halt_WB,
  output logic        pc_en,
  output logic        ifid_enable,
  output logic        ifid_flush,
  output logic        idex_enable,
  output logic        idex_flush,
  output logic        exmem_enable,
  output logic        memwb_enable,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;
  state_t      state_q, state_d;
  logic        halted_q, halted_d;
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic        dstall, lu, hold, redir, bubble;
  assign dstall = (dREN_MEM | dWEN_MEM) & ~dhit;
  assign lu = memtoReg_EX & RegWr_EX & (wsel_EX != 5'd0) & (wsel_EX == rs_ID | wsel_EX == rt_ID);
  // While nRST is low only the ihit fetch bubble may shape the outputs.
  assign hold   = nRST & (state_q == HALTED | halt_WB | dstall);
  assign redir  = nRST & ~hold & redirect_EX;
  assign bubble = ~hold & ~redir & ((nRST & lu) | ~ihit);
  assign pc_en        = ~hold & ~bubble;
  assign ifid_enable  = ~hold & ~bubble;
  assign ifid_flush   = redir;
  assign idex_enable  = ~hold;
  assign idex_flush   = redir | bubble;
  assign exmem_enable = ~hold;
  assign memwb_enable = ~hold;
  assign halted       = halted_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;
  always_comb begin
    state_d = state_q == HALTED ? HALTED :
              (dstall | (state_q == DWAIT & ~dhit)) ? DWAIT :
              halt_WB ? HALTED : RUN;
    halted_d = state_d == HALTED;
    stall_cnt_d = (~pc_en & state_q != HALTED & stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    flush_cnt_d = (redir & flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      halted_q    <= 1'b0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_control.sv
// tb_hazard_control: directed and random stimulus scored against a
// priority-rule reference model through an expected-response queue.
module tb_hazard_control;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b1, dhit = 1'b0, dREN_MEM = 1'b0, dWEN_MEM = 1'b0;
  logic        memtoReg_EX = 1'b0, RegWr_EX = 1'b0, redirect_EX = 1'b0, halt_WB = 1'b0;
  logic [4:0]  wsel_EX = '0, rs_ID = '0, rt_ID = '0;
  logic        pc_en, ifid_enable, ifid_flush, idex_enable, idex_flush;
  logic        exmem_enable, memwb_enable, halted;
  logic [15:0] stall_cnt, flush_cnt;

  hazard_control dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dREN_MEM(dREN_MEM), .dWEN_MEM(dWEN_MEM),
    .memtoReg_EX(memtoReg_EX), .RegWr_EX(RegWr_EX), .wsel_EX(wsel_EX),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .redirect_EX(redirect_EX), .halt_WB(halt_WB),
    .pc_en(pc_en), .ifid_enable(ifid_enable), .ifid_flush(ifid_flush),
    .idex_enable(idex_enable), .idex_flush(idex_flush),
    .exmem_enable(exmem_enable), .memwb_enable(memwb_enable),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    bit nrst, ihit, dhit, dren, dwen, mtr, rw;
    bit [4:0] wsel, rs, rt;
    bit redir, halt;
  } stim_t;
  // ctl order: pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_en
  typedef struct packed {
    bit [6:0]  ctl;
    bit        halted;
    bit [15:0] sc, fc;
  } resp_t;

  localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2;
  localparam bit [6:0] FREEZE = 7'b0000000, REDIR = 7'b1111111,
                       BUBBLE = 7'b0001111, GO = 7'b1101011;

  resp_t q[$];
  int    m_state = M_RUN;
  int    m_stall = 0, m_flush = 0;
  int    errors = 0, checks = 0, cyc = 0;

  function automatic stim_t idle();
    stim_t s = '0;
    s.nrst = 1'b1;
    s.ihit = 1'b1;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.nrst  = $urandom_range(0, 149) != 0;
    s.ihit  = $urandom_range(0, 3) != 0;
    s.dhit  = $urandom_range(0, 2) != 0;
    s.dren  = $urandom_range(0, 3) == 0;
    s.dwen  = $urandom_range(0, 5) == 0;
    s.mtr   = $urandom_range(0, 2) == 0;
    s.rw    = $urandom_range(0, 3) != 0;
    s.wsel  = 5'($urandom_range(0, 3));
    s.rs    = 5'($urandom_range(0, 3));
    s.rt    = 5'($urandom_range(0, 3));
    s.redir = $urandom_range(0, 5) == 0;
    s.halt  = $urandom_range(0, 59) == 0;
    return s;
  endfunction

  // One cycle: drive at the falling edge, queue what the pipe should show,
  // then advance the model to what the next rising edge commits.
  task automatic cycle(input stim_t s);
    bit ds, lu;
    bit [6:0] act;
    resp_t e;
    @(negedge CLK);
    nRST = s.nrst; ihit = s.ihit; dhit = s.dhit; dREN_MEM = s.dren; dWEN_MEM = s.dwen;
    memtoReg_EX = s.mtr; RegWr_EX = s.rw; wsel_EX = s.wsel; rs_ID = s.rs; rt_ID = s.rt;
    redirect_EX = s.redir; halt_WB = s.halt;
    if (!s.nrst) begin
      m_state = M_RUN; m_stall = 0; m_flush = 0;
    end
    ds = (s.dren || s.dwen) && !s.dhit;
    lu = s.mtr && s.rw && s.wsel != 0 && (s.wsel == s.rs || s.wsel == s.rt);
    if (!s.nrst) act = s.ihit ? GO : BUBBLE;
    else if (m_state == M_HALT || s.halt || ds) act = FREEZE;
    else if (s.redir) act = REDIR;
    else if (lu || !s.ihit) act = BUBBLE;
    else act = GO;
    e.ctl = act;
    e.halted = m_state == M_HALT;
    e.sc = 16'(m_stall);
    e.fc = 16'(m_flush);
    q.push_back(e);
    if (s.nrst) begin
      if (!act[6] && m_state != M_HALT && m_stall < 65535) m_stall++;
      if (act == REDIR && m_flush < 65535) m_flush++;
      if (m_state == M_HALT) m_state = M_HALT;
      else if (ds || (m_state == M_WAIT && !s.dhit)) m_state = M_WAIT;
      else if (s.halt) m_state = M_HALT;
      else m_state = M_RUN;
    end
  endtask

  initial begin
    resp_t e, a;
    forever begin
      @(negedge CLK);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        a.ctl = {pc_en, ifid_enable, ifid_flush, idex_enable, idex_flush, exmem_enable, memwb_enable};
        a.halted = halted;
        a.sc = stall_cnt;
        a.fc = flush_cnt;
        checks++;
        cyc++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle%0d: got ctl=%b halted=%b stall=%h flush=%h, expected ctl=%b halted=%b stall=%h flush=%h",
                   cyc, a.ctl, a.halted, a.sc, a.fc, e.ctl, e.halted, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    stim_t s;
    s = idle(); s.nrst = 0; cycle(s);
    s.ihit = 0; cycle(s);
    cycle(idle()); cycle(idle());
    s = idle(); s.mtr = 1; s.rw = 1; s.wsel = 5; s.rs = 5; cycle(s);
    cycle(idle());
    s = idle(); s.dren = 1; repeat (3) cycle(s);
    s.dhit = 1; cycle(s);
    cycle(idle());
    s = idle(); s.redir = 1; s.ihit = 0; cycle(s);
    cycle(idle());
    s = idle(); s.mtr = 1; s.rw = 1; s.wsel = 0; s.rs = 0; cycle(s);
    s = idle(); s.halt = 1; cycle(s);
    s = idle(); s.redir = 1; cycle(s);
    s.ihit = 0; cycle(s);
    s.redir = 0; cycle(s);
    cycle(idle());
    s = idle(); s.nrst = 0; cycle(s);
    cycle(idle());
    s = idle(); s.halt = 1; s.dren = 1; repeat (2) cycle(s);
    s.dhit = 1; cycle(s);
    cycle(idle());
    s = idle(); s.nrst = 0; cycle(s);
    s = idle(); s.dwen = 1; repeat (2) cycle(s);
    s.nrst = 0; cycle(s);
    cycle(idle());
    repeat (3000) cycle(rnd());
    s = idle(); s.nrst = 0; cycle(s);
    s = idle(); s.dren = 1; repeat (65540) cycle(s);
    s.dhit = 1; cycle(s);
    cycle(idle());
    @(negedge CLK);
    #4;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
